// File: rtl/dfa_lookahead_mpram_if.sv
// Bus bundle for the lookahead multi-read-port RAM: one byte-enabled write
// port, a clear request and NUM_RD packed read ports.
interface dfa_lookahead_mpram_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_RD        = 2
);
    logic [ADDRESS_WIDTH-1:0]        wr_address;
    logic [DATA_WIDTH-1:0]           wr_writedata;
    logic [DATA_WIDTH/8-1:0]         wr_byteenable;
    logic                            wr_write;
    logic                            wr_waitrequest;
    logic                            clear;
    logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_address;
    logic [NUM_RD-1:0]               rd_read;
    logic [NUM_RD*DATA_WIDTH-1:0]    rd_readdata;

    modport master (
        output wr_address, wr_writedata, wr_byteenable, wr_write, clear,
               rd_address, rd_read,
        input  wr_waitrequest, rd_readdata
    );

    modport slave (
        input  wr_address, wr_writedata, wr_byteenable, wr_write, clear,
               rd_address, rd_read,
        output wr_waitrequest, rd_readdata
    );
endinterface

// File: rtl/dfa_lookahead_mpram.sv
// Single-write, multi-read RAM with 1-cycle registered reads, per-byte
// write-before-read lookahead on every port, and a self-clearing sequence.
module dfa_lookahead_mpram #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int NUM_RD         = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dfa_lookahead_mpram_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST    = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEARING, READY} state_e;

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] cnt_q;
    logic                     waitreq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEARING;
            cnt_q     <= LAST;
            waitreq_q <= 1'b1;
        end else begin
            case (state_q)
                CLEARING: begin
                    if (bus.clear) begin
                        cnt_q <= LAST;
                    end else if (CLEAR_ON_RESET == 0 || cnt_q == '0) begin
                        state_q   <= READY;
                        waitreq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - ADDRESS_WIDTH'(1);
                    end
                end
                default: begin
                    if (bus.clear) begin
                        state_q   <= CLEARING;
                        cnt_q     <= LAST;
                        waitreq_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.wr_waitrequest = waitreq_q;

    // The single effective write of this edge: user write when ready, the
    // zeroing write when clearing. It feeds both the array and the lookahead.
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [NB-1:0]            wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.wr_address;
        wr_data = bus.wr_writedata;
        wr_be   = bus.wr_byteenable;
        if (state_q == READY) begin
            wr_en = bus.wr_write && ({1'b0, bus.wr_address} < DEPTH_W);
        end else if (CLEAR_ON_RESET != 0) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end
    end

    // No reset on the array; reset_n only gates the enable so a reset edge
    // aborts the write in flight.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && reset_n) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0]    merged;
        logic [DATA_WIDTH-1:0]    rd_q;

        assign ra = bus.rd_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        always_comb begin
            merged = '0;
            if ({1'b0, ra} < DEPTH_W) merged = mem[ra];
            if (wr_en && wr_addr == ra) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)           rd_q <= '0;
            else if (bus.rd_read[k]) rd_q <= merged;
        end

        assign rd_data[k] = rd_q;
    end

    assign bus.rd_readdata = rd_data;
endmodule

// File: tb/tb_dfa_lookahead_mpram.sv
// Checks two RAM instances (clearing DEPTH=8, non-clearing DEPTH=1) against a
// byte-level memory model, a directed vector table and randomized traffic.
module tb_dfa_lookahead_mpram;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int NB = DW / 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]         wa;
        logic [DW-1:0]         wd;
        logic [NB-1:0]         be;
        logic                  we;
        logic                  clr;
        logic [NR-1:0][AW-1:0] ra;
        logic [NR-1:0]         rr;
    } stim_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NB-1:0] be;
        logic          clr;
        logic [NR-1:0] rr;
        logic [AW-1:0] ra0, ra1;
        logic          ew;
        logic [DW-1:0] e0, e1;
    } vec_t;

    stim_t            st [2];
    logic             wq [2];
    logic [NR*DW-1:0] rdo [2];

    dfa_lookahead_mpram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(NR)) b0 ();
    dfa_lookahead_mpram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(NR)) b1 ();

    dfa_lookahead_mpram #(.DATA_WIDTH(DW), .DEPTH(8), .ADDRESS_WIDTH(AW), .NUM_RD(NR),
                          .CLEAR_ON_RESET(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
    dfa_lookahead_mpram #(.DATA_WIDTH(DW), .DEPTH(1), .ADDRESS_WIDTH(AW), .NUM_RD(NR),
                          .CLEAR_ON_RESET(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

    assign b0.wr_address = st[0].wa;  assign b1.wr_address = st[1].wa;
    assign b0.wr_writedata = st[0].wd; assign b1.wr_writedata = st[1].wd;
    assign b0.wr_byteenable = st[0].be; assign b1.wr_byteenable = st[1].be;
    assign b0.wr_write = st[0].we;    assign b1.wr_write = st[1].we;
    assign b0.clear = st[0].clr;      assign b1.clear = st[1].clr;
    assign b0.rd_address = st[0].ra;  assign b1.rd_address = st[1].ra;
    assign b0.rd_read = st[0].rr;     assign b1.rd_read = st[1].rr;
    assign wq[0] = b0.wr_waitrequest; assign wq[1] = b1.wr_waitrequest;
    assign rdo[0] = b0.rd_readdata;   assign rdo[1] = b1.rd_readdata;

    // Reference model: memory bytes plus a per-byte "known" flag, since
    // contents are undefined until written or cleared.
    int            depth [2] = '{8, 1};
    int            cor   [2] = '{1, 0};
    logic [DW-1:0] mm [2][8];
    logic [NB-1:0] mk [2][8];
    logic [DW-1:0] ed [2][NR];
    logic [NB-1:0] ek [2][NR];
    logic          mbusy [2];
    int            mcnt  [2];
    int            nt = 0;
    int            nf = 0;
    vec_t          tbl [$];

    function automatic logic [DW-1:0] bmask(input logic [NB-1:0] k);
        logic [DW-1:0] m;
        for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp,
                       input logic [DW-1:0] msk);
        nt++;
        if ((act & msk) !== (exp & msk)) begin
            nf++;
            $display("FAIL %s: got %h expected %h (mask %h) t=%0t", nm, act, exp, msk, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mbusy[i] = 1'b1;
            mcnt[i]  = depth[i] - 1;
            for (int k = 0; k < NR; k++) begin ed[i][k] = '0; ek[i][k] = '1; end
            for (int a = 0; a < 8; a++) mk[i][a] = '0;
        end
    endtask

    // One clock edge: apply the edge's write first, then the reads see it.
    task automatic model_edge(input int i);
        logic          we;
        int            wa;
        logic [DW-1:0] wd;
        logic [NB-1:0] be;
        int            ra;
        we = 1'b0; wa = 0; wd = '0; be = '0;
        if (!mbusy[i]) begin
            if (st[i].we && int'(st[i].wa) < depth[i]) begin
                we = 1'b1; wa = int'(st[i].wa); wd = st[i].wd; be = st[i].be;
            end
        end else if (cor[i] != 0) begin
            we = 1'b1; wa = mcnt[i]; wd = '0; be = '1;
        end
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin mm[i][wa][8*b +: 8] = wd[8*b +: 8]; mk[i][wa][b] = 1'b1; end
            end
        end
        for (int k = 0; k < NR; k++) begin
            if (st[i].rr[k]) begin
                ra = int'(st[i].ra[k]);
                if (ra < depth[i]) begin ed[i][k] = mm[i][ra]; ek[i][k] = mk[i][ra]; end
                else begin ed[i][k] = '0; ek[i][k] = '1; end
            end
        end
        if (mbusy[i]) begin
            if (st[i].clr) mcnt[i] = depth[i] - 1;
            else if (cor[i] == 0 || mcnt[i] == 0) mbusy[i] = 1'b0;
            else mcnt[i] = mcnt[i] - 1;
        end else if (st[i].clr) begin
            mbusy[i] = 1'b1;
            mcnt[i]  = depth[i] - 1;
        end
    endtask

    task automatic check(input int i, input string nm);
        cmp($sformatf("%s u%0d wait", nm, i), DW'(wq[i]), DW'(mbusy[i]), '1);
        for (int k = 0; k < NR; k++)
            cmp($sformatf("%s u%0d rd%0d", nm, i, k), rdo[i][k*DW +: DW], ed[i][k], bmask(ek[i][k]));
    endtask

    task automatic cyc(input string nm);
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check(0, nm);
        check(1, nm);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check(0, "reset");
        check(1, "reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic void add(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [NB-1:0] be, input logic clr, input logic [NR-1:0] rr,
                                input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                input logic ew, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.clr = clr; v.rr = rr;
        v.ra0 = ra0; v.ra1 = ra1; v.ew = ew; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        st[0] = '0;
        st[1] = '0;

        // Clearing after reset: 8 busy cycles, then a sweep of zeros.
        for (int j = 0; j < 8; j++) add(0, 0, 0, 0, 0, 2'b00, 0, 0, (j < 7), 16'h0, 16'h0);
        for (int j = 0; j < 8; j++) add(0, 0, 0, 0, 0, 2'b11, AW'(j), AW'(7 - j), 0, 16'h0, 16'h0);
        add(1, 3, 16'hA5A5, 2'b11, 0, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 2'b00, 0, 2'b11, 3, 3, 0, 16'hA5A5, 16'hA5A5);
        add(1, 5, 16'h1234, 2'b11, 0, 2'b00, 0, 0, 0, 16'hA5A5, 16'hA5A5);
        add(1, 5, 16'hBEEF, 2'b01, 0, 2'b11, 5, 6, 0, 16'h12EF, 16'h0000);
        add(1, 6, 16'hFFFF, 2'b11, 0, 2'b01, 5, 5, 0, 16'h12EF, 16'h0000);
        add(1, 5, 16'h5500, 2'b10, 0, 2'b01, 6, 3, 0, 16'hFFFF, 16'h0000);
        add(0, 0, 16'h0000, 2'b00, 0, 2'b01, 5, 2, 0, 16'h55EF, 16'h0000);
        add(0, 0, 16'h0000, 2'b00, 0, 2'b10, 0, 6, 0, 16'h55EF, 16'hFFFF);
        add(1, 6, 16'h0000, 2'b00, 0, 2'b11, 6, 6, 0, 16'hFFFF, 16'hFFFF);
        add(1, 9, 16'h1111, 2'b11, 0, 2'b11, 9, 1, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 2'b00, 0, 2'b11, 1, 9, 0, 16'h0000, 16'h0000);
        add(1, 2, 16'hCAFE, 2'b11, 0, 2'b11, 2, 2, 0, 16'hCAFE, 16'hCAFE);
        for (int j = 0; j < 8; j++) add(1, AW'(j), 16'hFFFF, 2'b11, 0, 2'b00, 0, 0, 0, 16'hCAFE, 16'hCAFE);
        add(0, 0, 16'h0000, 2'b00, 1, 2'b00, 0, 0, 1, 16'hCAFE, 16'hCAFE);
        add(0, 0, 16'h0000, 2'b00, 0, 2'b11, 7, 6, 1, 16'h0000, 16'hFFFF);
        for (int j = 1; j < 7; j++) add(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 16'h0000, 16'hFFFF);
        add(1, 7, 16'h1234, 2'b11, 0, 2'b00, 0, 0, 0, 16'h0000, 16'hFFFF);
        for (int j = 0; j < 4; j++) add(0, 0, 0, 0, 0, 2'b11, AW'(j), AW'(j + 4), 0, 16'h0, 16'h0);

        #2;
        do_reset();

        foreach (tbl[j]) begin
            st[0].we = tbl[j].we;   st[0].wa = tbl[j].wa; st[0].wd = tbl[j].wd;
            st[0].be = tbl[j].be;   st[0].clr = tbl[j].clr; st[0].rr = tbl[j].rr;
            st[0].ra[0] = tbl[j].ra0; st[0].ra[1] = tbl[j].ra1;
            cyc("tbl");
            cmp($sformatf("vec%0d wait", j), DW'(wq[0]), DW'(tbl[j].ew), '1);
            cmp($sformatf("vec%0d rd0", j), rdo[0][DW-1:0], tbl[j].e0, '1);
            cmp($sformatf("vec%0d rd1", j), rdo[0][2*DW-1:DW], tbl[j].e1, '1);
        end

        // Non-clearing instance: clear gives exactly one busy cycle.
        st[0] = '0;
        st[1] = '0;
        st[1].clr = 1'b1;
        cyc("clr1");
        cmp("u1 clear busy", DW'(wq[1]), 16'h1, '1);
        st[1].clr = 1'b0;
        cyc("clr1b");
        cmp("u1 clear done", DW'(wq[1]), 16'h0, '1);

        // Reset in the middle of a clear restarts a full-length sequence.
        st[0].clr = 1'b1;
        cyc("mclr");
        st[0].clr = 1'b0;
        repeat (3) cyc("mclr");
        do_reset();
        n = 0;
        while (wq[0] && n < 20) begin
            cyc("rclr");
            n++;
        end
        cmp("busy cycles after mid-clear reset", DW'(n), 16'd8, '1);

        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                st[i].we  = 1'($urandom_range(0, 1));
                st[i].wa  = AW'($urandom_range(0, depth[i] + 1));
                st[i].wd  = DW'($urandom);
                st[i].be  = NB'($urandom);
                st[i].clr = ($urandom_range(0, 63) == 0);
                st[i].rr  = NR'($urandom);
                for (int k = 0; k < NR; k++) begin
                    if ($urandom_range(0, 2) == 0) st[i].ra[k] = st[i].wa;
                    else st[i].ra[k] = AW'($urandom_range(0, depth[i] + 1));
                end
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
